// File: rtl/wb_pkg.sv
// Shared types and constants for the D-side write-back scheduler.
package wb_pkg;

  // Byte offset inside a 32-byte line; line address is addr[ADDR_W-1:OFFSET_W].
  localparam int OFFSET_W = 5;

  // Default geometry, used to give the entry struct a concrete shape.
  localparam int WB_ADDR_W = 32;
  localparam int WB_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } wb_state_e;

  // One buffered dirty line at the default geometry.
  typedef struct packed {
    logic                            valid;
    logic [WB_ADDR_W-OFFSET_W-1:0]   line_addr;
    logic [WB_LINE_W-1:0]            data;
  } wb_entry_t;

endpackage

// File: rtl/wb_store.sv
// Circular line buffer for wb_scheduler: entry array, head/tail/count,
// parallel address match, and push / in-place overwrite / pop ports.
module wb_store
  import wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256,
  parameter int LA_W   = 27,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [LA_W-1:0]   push_addr_i,
  input  logic [LINE_W-1:0] push_data_i,
  input  logic              ovw_i,
  input  logic [PTR_W-1:0]  ovw_idx_i,
  input  logic [LINE_W-1:0] ovw_data_i,
  input  logic              pop_i,
  input  logic [LA_W-1:0]   match_addr_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  hit_idx_o,
  output logic [LINE_W-1:0] hit_data_o,
  output logic [LA_W-1:0]   head_addr_o,
  output logic [LINE_W-1:0] head_data_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o
);

  // Same layout as wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic [LA_W-1:0]   line_addr;
    logic [LINE_W-1:0] data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // Entry array and pointers; push at tail, pop at head, overwrite in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        ent_q[tail_q] <= '{valid: 1'b1, line_addr: push_addr_i, data: push_data_i};
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (ovw_i) ent_q[ovw_idx_i].data <= ovw_data_i;
      if (pop_i) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Parallel match; coalescing keeps line addresses unique, so first hit wins.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit_o && ent_q[i].valid && (ent_q[i].line_addr == match_addr_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = PTR_W'(i);
      end
    end
  end

  assign hit_data_o  = ent_q[hit_idx_o].data;
  assign head_addr_o = ent_q[head_q].line_addr;
  assign head_data_o = ent_q[head_q].data;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign count_o     = count_q;

endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler between the D-cache and the D-side memory port.
// Dirty victims are absorbed into wb_store and acked in one cycle; buffered
// lines drain oldest-first whenever the port would otherwise idle.
// Build option WB_FORWARD_EN: when defined, read hits on buffered lines are
// served from the buffer; when undefined, such reads drain the buffer until
// the line is gone and then read from memory.
// Handshake: dc_read_i/dc_write_i are held until the one-cycle dc_resp_o;
// mem_read_o/mem_write_o are held with stable address/data until the
// one-cycle mem_resp_i, and are never both high.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  localparam int LA_W  = ADDR_W - OFFSET_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_read_i,
  input  logic              dc_write_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_resp_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output wb_state_e         state_o
);

  wb_state_e         state_q, state_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic [LA_W-1:0]   dc_line;
  logic              push, ovw, pop;
  logic              hit, full;
  logic [PTR_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_data, head_data;
  logic [LA_W-1:0]   head_addr;
  logic [CNT_W-1:0]  count;

  assign dc_line = dc_addr_i[ADDR_W-1:OFFSET_W];

  // Byte offset within the line plays no part in line-granular requests.
  logic unused_offset;
  assign unused_offset = ^dc_addr_i[OFFSET_W-1:0];

  wb_store #(
    .DEPTH (DEPTH),
    .LINE_W(LINE_W),
    .LA_W  (LA_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (dc_line),
    .push_data_i (dc_wdata_i),
    .ovw_i       (ovw),
    .ovw_idx_i   (hit_idx),
    .ovw_data_i  (dc_wdata_i),
    .pop_i       (pop),
    .match_addr_i(dc_line),
    .hit_o       (hit),
    .hit_idx_o   (hit_idx),
    .hit_data_o  (hit_data),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (full),
    .count_o     (count)
  );

`ifndef WB_FORWARD_EN
  // Without forwarding the buffered copy is never returned to the D-cache.
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
`endif

  // State and forwarded-read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, buffer control and output muxing.
  always_comb begin
    state_d     = state_q;
    rdata_d     = '0;
    push        = 1'b0;
    ovw         = 1'b0;
    pop         = 1'b0;
    dc_resp_o   = 1'b0;
    dc_rdata_o  = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (dc_read_i) begin
`ifdef WB_FORWARD_EN
          if (hit) begin
            rdata_d = hit_data;
            state_d = RESP;
          end else begin
            state_d = RD;
          end
`else
          // A buffered copy is newer than memory: drain it out first.
          state_d = hit ? WR : RD;
`endif
        end else if (dc_write_i) begin
          if (hit) begin
            ovw     = 1'b1;
            state_d = RESP;
          end else if (!full) begin
            push    = 1'b1;
            state_d = RESP;
          end else begin
            // Make room; the held write is retried on return to IDLE.
            state_d = WR;
          end
        end else if (count != '0) begin
          state_d = WR;
        end
      end
      RESP: begin
        dc_resp_o  = 1'b1;
        dc_rdata_o = rdata_q;
        state_d    = IDLE;
      end
      RD: begin
        mem_read_o = 1'b1;
        mem_addr_o = {dc_line, {OFFSET_W{1'b0}}};
        if (mem_resp_i) begin
          dc_rdata_o = mem_rdata_i;
          dc_resp_o  = 1'b1;
          state_d    = IDLE;
        end
      end
      WR: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {head_addr, {OFFSET_W{1'b0}}};
        mem_wdata_o = head_data;
        if (mem_resp_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_o = count;
  assign empty_o = (count == '0);
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios followed by a
// randomized request stream, checked against a line-level coherence model.
module tb_wb_scheduler;
  import wb_pkg::*;

  localparam int DEPTH  = 2;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int LA_W   = ADDR_W - 5;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] dc_addr_i;
  logic              dc_read_i;
  logic              dc_write_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic [LINE_W-1:0] dc_rdata_o;
  logic              dc_resp_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_resp_i;
  logic [CNT_W-1:0]  count_o;
  logic              empty_o;
  wb_state_e         state_o;

  wb_scheduler #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .dc_addr_i  (dc_addr_i),
    .dc_read_i  (dc_read_i),
    .dc_write_i (dc_write_i),
    .dc_wdata_i (dc_wdata_i),
    .dc_rdata_o (dc_rdata_o),
    .dc_resp_o  (dc_resp_o),
    .mem_addr_o (mem_addr_o),
    .mem_read_o (mem_read_o),
    .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_resp_i (mem_resp_i),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .state_o    (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending dirty lines in drain order (coalesced), latest value per line as
  // seen by the D-cache, and the contents of backing memory.
  typedef struct {
    logic [LA_W-1:0]   line;
    logic [LINE_W-1:0] data;
  } ent_t;
  ent_t              model_q[$];
  logic [LINE_W-1:0] shadow [logic [LA_W-1:0]];
  logic [LINE_W-1:0] mem_a  [logic [LA_W-1:0]];

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    int                cyc;
  } log_t;
  log_t mem_log[$];

  function automatic logic [LINE_W-1:0] dflt(input logic [LA_W-1:0] l);
    logic [31:0] w;
    w = {5'b0, l} ^ 32'h5A5A_0000;
    return {8{w}};
  endfunction

  function automatic logic [LINE_W-1:0] mem_val(input logic [LA_W-1:0] l);
    return mem_a.exists(l) ? mem_a[l] : dflt(l);
  endfunction

  function automatic logic [LINE_W-1:0] exp_read(input logic [LA_W-1:0] l);
    return shadow.exists(l) ? shadow[l] : dflt(l);
  endfunction

  function automatic bit model_has(input logic [LA_W-1:0] l);
    foreach (model_q[i]) if (model_q[i].line == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_write(input logic [LA_W-1:0] l, input logic [LINE_W-1:0] d);
    ent_t e;
    shadow[l] = d;
    foreach (model_q[i]) begin
      if (model_q[i].line == l) begin
        model_q[i].data = d;
        return;
      end
    end
    e.line = l;
    e.data = d;
    model_q.push_back(e);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- memory responder ----------------
  bit              m_busy = 1'b0;
  bit              m_wr;
  int              m_cnt;
  logic [LA_W-1:0] m_line;

  initial begin
    mem_resp_i  = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp_i  = 1'b0;
      mem_rdata_i = '0;
      if (rst) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          mem_resp_i = 1'b1;
          if (!m_wr) mem_rdata_i = mem_val(m_line);
          m_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (mem_read_o || mem_write_o) begin
        m_busy = 1'b1;
        m_wr   = mem_write_o;
        m_line = mem_addr_o[ADDR_W-1:5];
        m_cnt  = $urandom_range(0, 3);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit                prev_act = 1'b0;
  logic [ADDR_W-1:0] t_addr;
  logic [LINE_W-1:0] t_data;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
      end else begin
        log_t lg;
        check("mem_excl", mem_read_o & mem_write_o, 0);
        if (mem_read_o || mem_write_o) begin
          if (!prev_act) begin
            t_addr  = mem_addr_o;
            t_data  = mem_wdata_o;
            lg.wr   = mem_write_o;
            lg.addr = mem_addr_o;
            lg.data = mem_wdata_o;
            lg.cyc  = cyc;
            mem_log.push_back(lg);
            check("mem_addr_align", mem_addr_o[4:0], 0);
            if (mem_read_o) check("rd_of_buffered_line", model_has(mem_addr_o[ADDR_W-1:5]), 0);
          end else begin
            check("mem_addr_stable", mem_addr_o, t_addr);
            if (mem_write_o) check("mem_wdata_stable", mem_wdata_o, t_data);
          end
        end
        if (dc_resp_o && dc_read_i)
          check("rd_data", dc_rdata_o, exp_read(dc_addr_i[ADDR_W-1:5]));
        if (dc_resp_o && dc_write_i && !dc_read_i)
          model_write(dc_addr_i[ADDR_W-1:5], dc_wdata_i);
        check("count", count_o, model_q.size());
        check("empty", empty_o, model_q.size() == 0);
        if (mem_write_o && mem_resp_i) begin
          check("drain_nonempty", model_q.size() != 0, 1);
          if (model_q.size() != 0) begin
            check("drain_addr", mem_addr_o, {model_q[0].line, 5'b0});
            check("drain_data", mem_wdata_o, model_q[0].data);
            void'(model_q.pop_front());
          end
          mem_a[mem_addr_o[ADDR_W-1:5]] = mem_wdata_o;
        end
        prev_act = (mem_read_o || mem_write_o) && !mem_resp_i;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; presents a request, waits for dc_resp_o, and returns
  // at posedge+1 of the cycle after the response with the request dropped.
  // lat = cycles from the request cycle to the response cycle.
  task automatic dc_op(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, output int lat);
    int n;
    dc_addr_i  = a;
    dc_wdata_i = d;
    dc_read_i  = !wr;
    dc_write_i = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dc_resp_o && n < 300);
    if (!dc_resp_o) check("dc_resp_timeout", 0, 1);
    @(posedge clk);
    #1;
    dc_read_i  = 1'b0;
    dc_write_i = 1'b0;
    dc_wdata_i = '0;
    lat = n - 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (!(empty_o && !mem_write_o && !mem_read_o) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_timeout", k < 500, 1);
  endtask

  // Synchronous reset pulse; buffered data is lost, memory keeps its contents.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    shadow = mem_a;
    mem_log.delete();
  endtask

  // ---------------- stimulus ----------------
  int                lat;
  int                rc;
  int                k;
  int                nrd;
  logic [LINE_W-1:0] da, db, dcv;

  initial begin
    rst        = 1'b1;
    dc_addr_i  = '0;
    dc_read_i  = 1'b0;
    dc_write_i = 1'b0;
    dc_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_dc_resp", dc_resp_o, 0);
    check("rst_dc_rdata", dc_rdata_o, 0);
    check("rst_mem_read", mem_read_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_state", state_o, IDLE);
    @(posedge clk);
    #1;

    // Single write: one-cycle ack, then drain starts the cycle after IDLE
    da = rand_line();
    dc_op(1'b1, 32'h1000, da, lat);
    check("wr_ack_latency", lat, 1);
    @(negedge clk);
    @(negedge clk);
    check("drain_start_write", mem_write_o, 1);
    check("drain_start_addr", mem_addr_o, 32'h1000);
    check("drain_start_data", mem_wdata_o, da);
    @(posedge clk);
    #1;
    wait_empty();
    check("t1_count_after", count_o, 0);
    check("t1_empty_after", empty_o, 1);

    // Write then read miss: the read reaches memory before the drain
    mem_log.delete();
    da = rand_line();
    dc_op(1'b1, 32'h1000, da, lat);
    rc = cyc;
    dc_op(1'b0, 32'h2000, '0, lat);
    wait_empty();
    check("t2_log_size", mem_log.size() >= 2, 1);
    check("t2_first_is_read", mem_log[0].wr, 0);
    check("t2_first_addr", mem_log[0].addr, 32'h2000);
    check("t2_read_issue_cycle", mem_log[0].cyc, rc + 1);
    check("t2_second_is_write", mem_log[1].wr, 1);
    check("t2_second_addr", mem_log[1].addr, 32'h1000);

    // Read of a buffered line (offset within the line)
    mem_log.delete();
    da = rand_line();
    dc_op(1'b1, 32'h1000, da, lat);
    dc_op(1'b0, 32'h1010, '0, lat);
`ifdef WB_FORWARD_EN
    check("t3_hit_latency", lat, 1);
    wait_empty();
    nrd = 0;
    foreach (mem_log[i]) if (!mem_log[i].wr) nrd++;
    check("t3_no_mem_read", nrd, 0);
`else
    wait_empty();
    check("t3_log_size", mem_log.size() >= 2, 1);
    check("t3_first_is_write", mem_log[0].wr, 1);
    check("t3_first_addr", mem_log[0].addr, 32'h1000);
    check("t3_then_read", mem_log[1].wr, 0);
    check("t3_read_addr", mem_log[1].addr, 32'h1000);
`endif

    // Coalescing two writes to one line
    mem_log.delete();
    da = rand_line();
    db = rand_line();
    dc_op(1'b1, 32'h1000, da, lat);
    dc_op(1'b1, 32'h1000, db, lat);
    check("t4_count", count_o, 1);
    wait_empty();
    check("t4_one_drain", mem_log.size(), 1);
    check("t4_drain_data", mem_log[0].data, db);

    // Full buffer: third write is held until the oldest line drains
    mem_log.delete();
    dc_op(1'b1, 32'h1000, rand_line(), lat);
    dc_op(1'b1, 32'h2000, rand_line(), lat);
    dc_op(1'b1, 32'h3000, rand_line(), lat);
    check("t5_third_held", lat >= 3, 1);
    check("t5_count", count_o, 2);
    check("t5_first_drain", mem_log[0].addr, 32'h1000);
    wait_empty();

    // Reset while a drain write is in flight
    dcv = rand_line();
    dc_op(1'b1, 32'h5000, dcv, lat);
    k = 0;
    while (!mem_write_o && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t6_write_seen", mem_write_o, 1);
    do_reset();
    @(negedge clk);
    check("t6_mem_write", mem_write_o, 0);
    check("t6_mem_read", mem_read_o, 0);
    check("t6_mem_addr", mem_addr_o, 0);
    check("t6_mem_wdata", mem_wdata_o, 0);
    check("t6_dc_resp", dc_resp_o, 0);
    check("t6_count", count_o, 0);
    check("t6_empty", empty_o, 1);
    check("t6_state", state_o, IDLE);
    @(posedge clk);
    #1;

    // Randomized traffic over a small set of lines to exercise hits
    repeat (300) begin
      int r;
      logic [ADDR_W-1:0] a;
      r = $urandom_range(0, 9);
      a = (ADDR_W'($urandom_range(1, 6)) << 12) | ADDR_W'($urandom_range(0, 31));
      if (r < 4)      dc_op(1'b1, a, rand_line(), lat);
      else if (r < 8) dc_op(1'b0, a, '0, lat);
      else            idle($urandom_range(1, 6));
    end
    wait_empty();
    check("final_count", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
